// File: rtl/df_start_ctrl.sv
// Start-token controller: pops a token from the start FIFO, drives one ap_start/ap_done/ap_continue iteration per token.
// Optional token prefetch is enabled by defining DF_START_CTRL_PREFETCH_EN.
module df_start_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_n,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic                  ap_continue,
    output logic [DATA_WIDTH-1:0] token_out,
    output logic                  done_valid,
    input  logic                  done_ack,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  iter_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_START    = 2'd1,
        S_RUN      = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] token_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic                  enter_complete;

    assign enter_complete = ((state_reg == S_START) && ap_ready && ap_done) ||
                            ((state_reg == S_RUN) && ap_done);

`ifdef DF_START_CTRL_PREFETCH_EN
    logic                  pf_valid_reg;
    logic [DATA_WIDTH-1:0] pf_data_reg;
    logic                  pf_pop;

    assign pf_pop    = ((state_reg == S_RUN) || (state_reg == S_COMPLETE)) &&
                       fifo_empty_n && !pf_valid_reg;
    // No pop during reset: the in-flight token is dropped, the FIFO head is kept.
    assign fifo_read = !reset &&
                       (((state_reg == S_IDLE) && fifo_empty_n && !pf_valid_reg) || pf_pop);
`else
    assign fifo_read = !reset && (state_reg == S_IDLE) && fifo_empty_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            token_reg <= '0;
            count_reg <= '0;
`ifdef DF_START_CTRL_PREFETCH_EN
            pf_valid_reg <= 1'b0;
            pf_data_reg  <= '0;
`endif
        end else begin
            if (enter_complete) begin
                count_reg <= count_reg + 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (fifo_read) begin
                        token_reg <= fifo_dout;
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (ap_ready) begin
                        state_reg <= ap_done ? S_COMPLETE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (ap_done) begin
                        state_reg <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    if (done_ack) begin
`ifdef DF_START_CTRL_PREFETCH_EN
                        if (pf_valid_reg) begin
                            token_reg    <= pf_data_reg;
                            pf_valid_reg <= 1'b0;
                            state_reg    <= S_START;
                        end else if (pf_pop) begin
                            // Token popped on the leaving edge goes straight to execution.
                            token_reg <= fifo_dout;
                            state_reg <= S_START;
                        end else begin
                            state_reg <= S_IDLE;
                        end
`else
                        state_reg <= S_IDLE;
`endif
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
`ifdef DF_START_CTRL_PREFETCH_EN
            if (pf_pop && !((state_reg == S_COMPLETE) && done_ack)) begin
                pf_valid_reg <= 1'b1;
                pf_data_reg  <= fifo_dout;
            end
`endif
        end
    end

    assign ap_start    = (state_reg == S_START);
    assign ap_continue = (state_reg == S_COMPLETE);
    assign done_valid  = (state_reg == S_COMPLETE);
    assign busy        = (state_reg != S_IDLE);
    assign token_out   = token_reg;
    assign iter_count  = count_reg;

endmodule
